// File: rtl/voxel_point_accumulator.sv
// rtl/voxel_point_accumulator.sv - LiDAR point to voxel read-modify-write accumulator; stats under VOXEL_ACC_STATS_EN
module voxel_point_accumulator #(
   parameter int VOXEL_SHIFT = 6,
   parameter int MISS_LAT    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pt_valid,
   output logic        pt_ready,
   input  logic [15:0] pt_x,
   input  logic [15:0] pt_y,
   input  logic [15:0] pt_z,
   input  logic [7:0]  pt_intensity,
   output logic [14:0] voxel_addr,
   output logic        read_en,
   output logic        write_en,
   output logic [31:0] voxel_data_in,
   input  logic        cache_hit,
   input  logic [31:0] cache_data,
   output logic        busy
`ifdef VOXEL_ACC_STATS_EN
   ,
   output logic [15:0] drop_cnt,
   output logic [15:0] sat_cnt
`endif
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] RD_REQ    = 3'd1;
   localparam logic [2:0] RD_WAIT   = 3'd2;
   localparam logic [2:0] MISS_WAIT = 3'd3;
   localparam logic [2:0] WR        = 3'd4;

   localparam logic [2:0] MISS_LAT_C = 3'(MISS_LAT);

   logic [2:0]  state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [7:0]  int_q, int_d;
   logic [14:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic        read_en_q, read_en_d;
   logic        write_en_q, write_en_d;
   logic        pt_ready_q, pt_ready_d;
   logic        busy_q, busy_d;
`ifdef VOXEL_ACC_STATS_EN
   logic [15:0] drop_q, drop_d;
   logic [15:0] sat_q, sat_d;
`endif

   // Per-axis voxel index in 17-bit signed arithmetic; in range means 0..31
   logic signed [16:0] vx, vy, vz;
   logic               in_range;
   assign vx = ($signed({pt_x[15], pt_x}) >>> VOXEL_SHIFT) + 17'sd16;
   assign vy = ($signed({pt_y[15], pt_y}) >>> VOXEL_SHIFT) + 17'sd16;
   assign vz = ($signed({pt_z[15], pt_z}) >>> VOXEL_SHIFT) + 17'sd16;
   assign in_range = (vx[16:5] == 12'd0) && (vy[16:5] == 12'd0) && (vz[16:5] == 12'd0);

   // Updated voxel word built from the sampled cache word and the latched intensity
   logic [31:0] upd_word;
   logic        old_sat;
   assign old_sat  = (cache_data[31:16] == 16'hFFFF);
   assign upd_word = {old_sat ? 16'hFFFF : cache_data[31:16] + 16'd1,
                      (cache_data[15:8] > int_q) ? cache_data[15:8] : int_q,
                      int_q};

   // Next-state logic for the serialised read-modify-write sequence
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      int_d      = int_q;
      addr_d     = addr_q;
      data_d     = data_q;
      read_en_d  = 1'b0;
      write_en_d = 1'b0;
`ifdef VOXEL_ACC_STATS_EN
      drop_d     = drop_q;
      sat_d      = sat_q;
`endif
      case (state_q)
         IDLE: begin
            if (pt_valid && pt_ready_q) begin
               if (in_range) begin
                  addr_d    = {vz[4:0], vy[4:0], vx[4:0]};
                  int_d     = pt_intensity;
                  read_en_d = 1'b1;
                  state_d   = RD_REQ;
               end else begin
`ifdef VOXEL_ACC_STATS_EN
                  drop_d = drop_q + 16'd1;
`endif
               end
            end
         end
         RD_REQ: state_d = RD_WAIT;
         RD_WAIT: begin
            if (cache_hit) begin
               data_d     = upd_word;
               write_en_d = 1'b1;
               state_d    = WR;
`ifdef VOXEL_ACC_STATS_EN
               if (old_sat) sat_d = sat_q + 16'd1;
`endif
            end else begin
               cnt_d   = MISS_LAT_C;
               state_d = MISS_WAIT;
            end
         end
         MISS_WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               data_d     = upd_word;
               write_en_d = 1'b1;
               state_d    = WR;
`ifdef VOXEL_ACC_STATS_EN
               if (old_sat) sat_d = sat_q + 16'd1;
`endif
            end
         end
         WR:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
      pt_ready_d = (state_d == IDLE);
      busy_d     = (state_d != IDLE);
   end

   // State and registered outputs; reset aborts any pending write
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 3'd0;
         int_q      <= 8'd0;
         addr_q     <= 15'd0;
         data_q     <= 32'd0;
         read_en_q  <= 1'b0;
         write_en_q <= 1'b0;
         pt_ready_q <= 1'b0;
         busy_q     <= 1'b0;
`ifdef VOXEL_ACC_STATS_EN
         drop_q     <= 16'd0;
         sat_q      <= 16'd0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         int_q      <= int_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         read_en_q  <= read_en_d;
         write_en_q <= write_en_d;
         pt_ready_q <= pt_ready_d;
         busy_q     <= busy_d;
`ifdef VOXEL_ACC_STATS_EN
         drop_q     <= drop_d;
         sat_q      <= sat_d;
`endif
      end
   end

   assign pt_ready      = pt_ready_q;
   assign voxel_addr    = addr_q;
   assign read_en       = read_en_q;
   assign write_en      = write_en_q;
   assign voxel_data_in = data_q;
   assign busy          = busy_q;
`ifdef VOXEL_ACC_STATS_EN
   assign drop_cnt      = drop_q;
   assign sat_cnt       = sat_q;
`endif

endmodule
